divider_fu: RTL and testbench



---
 rtl/fu_pkg.sv | 14 +
 rtl/divider_step.sv | 30 +++
 rtl/divider_fu.sv | 120 ++++++++++++
 tb/tb_divider_fu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the s_tile functional units: default datapath widths
// and the divider FSM state encoding.
package fu_pkg;

   localparam int unsigned FU_DATA_WIDTH    = 8;
   localparam int unsigned FU_PRODUCT_WIDTH = 2 * FU_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } divider_state_t;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module divider_step #(
   parameter int unsigned DIVISOR_WIDTH = 8
) (
   input  logic [DIVISOR_WIDTH:0]   partial_rem_i,
   input  logic                     dividend_bit_i,
   input  logic [DIVISOR_WIDTH-1:0] divisor_i,
   output logic [DIVISOR_WIDTH:0]   partial_rem_o,
   output logic                     quot_bit_o
);

   logic [DIVISOR_WIDTH+1:0] shifted;
   logic [DIVISOR_WIDTH+1:0] diff;
   logic [DIVISOR_WIDTH+1:0] result;
   logic                     unused_result_msb;

   always_comb begin
      shifted    = {partial_rem_i, dividend_bit_i};
      diff       = shifted - {2'b00, divisor_i};
      quot_bit_o = (shifted >= {2'b00, divisor_i});
      result     = quot_bit_o ? diff : shifted;
   end

   // The incoming remainder is always below the divisor, so the top bit of the
   // restored value is zero and can be dropped.
   assign partial_rem_o     = result[DIVISOR_WIDTH:0];
   assign unused_result_msb = result[DIVISOR_WIDTH+1];

endmodule

// File: rtl/divider_fu.sv
// Iterative unsigned restoring divider FU: one quotient bit per cycle with
// valid/ready handshakes on both sides, gated by the tile on_off bit.
module divider_fu
   import fu_pkg::*;
#(
   parameter int unsigned DIVIDEND_WIDTH = FU_PRODUCT_WIDTH,
   parameter int unsigned DIVISOR_WIDTH  = FU_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      on_off,
   input  logic                      valid_in,
   output logic                      ready_in,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      valid_out,
   input  logic                      ready_out,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero
);

   localparam int unsigned CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

   divider_state_t            state_q;
   logic [CNT_WIDTH-1:0]      cnt_q;
   logic [DIVIDEND_WIDTH-1:0] dvd_q;
   logic [DIVISOR_WIDTH-1:0]  dvs_q;
   logic [DIVISOR_WIDTH:0]    prem_q;
   logic [DIVIDEND_WIDTH-1:0] quo_q;
   logic [DIVISOR_WIDTH-1:0]  rem_q;
   logic                      dbz_q;
   logic                      valid_q;

   logic [DIVISOR_WIDTH:0]    prem_d;
   logic                      qbit_d;
   logic [DIVIDEND_WIDTH-1:0] dvd_d;

   divider_step #(
      .DIVISOR_WIDTH(DIVISOR_WIDTH)
   ) u_step (
      .partial_rem_i (prem_q),
      .dividend_bit_i(dvd_q[DIVIDEND_WIDTH-1]),
      .divisor_i     (dvs_q),
      .partial_rem_o (prem_d),
      .quot_bit_o    (qbit_d)
   );

   // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
   // after the last iteration the shift register holds the full quotient.
   assign dvd_d = {dvd_q[DIVIDEND_WIDTH-2:0], qbit_d};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_in && on_off) begin
                  dvd_q  <= dividend;
                  dvs_q  <= divisor;
                  prem_q <= '0;
                  cnt_q  <= CNT_WIDTH'(DIVIDEND_WIDTH);
                  if (divisor == '0) begin
                     quo_q   <= '1;
                     rem_q   <= '0;
                     dbz_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (!on_off) begin
                  quo_q   <= '0;
                  rem_q   <= '0;
                  dbz_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  dvd_q  <= dvd_d;
                  prem_q <= prem_d;
                  cnt_q  <= cnt_q - 1'b1;
                  if (cnt_q == CNT_WIDTH'(1)) begin
                     quo_q   <= dvd_d;
                     rem_q   <= prem_d[DIVISOR_WIDTH-1:0];
                     dbz_q   <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               if (ready_out) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_in    = (state_q == IDLE) && on_off;
   assign valid_out   = valid_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_fu.sv
// Directed bench for divider_fu: vector table of divisions plus hand-written
// backpressure, handoff, on_off abort and asynchronous reset sequences.
module tb_divider_fu;

   logic        clk;
   logic        reset_n;
   logic        on_off;
   logic        valid_in;
   logic        ready_in;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        valid_out;
   logic        ready_out;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int tests = 0;
   int fails = 0;

   divider_fu #(
      .DIVIDEND_WIDTH(16),
      .DIVISOR_WIDTH (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .on_off     (on_off),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .dividend   (dividend),
      .divisor    (divisor),
      .valid_out  (valid_out),
      .ready_out  (ready_out),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for valid_out, counting edges after the current one.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid_out && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Called #1 after a rising edge; presents one operation and waits for it.
   task automatic do_div(input logic [15:0] a, input logic [7:0] b, output int lat);
      dividend = a;
      divisor  = b;
      valid_in = 1'b1;
      #1;
      check("ready_in_before_accept", ready_in, 1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      wait_valid(lat);
   endtask

   task automatic handoff();
      ready_out = 1'b1;
      @(posedge clk);
      #1;
      ready_out = 1'b0;
      check("valid_drop_after_handoff", valid_out, 0);
   endtask

   initial begin
      int lat;
      int seen;

      vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, 16};
      vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, 16};
      vecs[2] = '{16'd5,     8'd9,   16'd0,     8'd5,  1'b0, 16};
      vecs[3] = '{16'd1234,  8'd0,   16'hFFFF,  8'd0,  1'b1, 0};
      vecs[4] = '{16'd100,   8'd10,  16'd10,    8'd0,  1'b0, 16};
      vecs[5] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, 16};
      vecs[6] = '{16'd255,   8'd16,  16'd15,    8'd15, 1'b0, 16};
      vecs[7] = '{16'd300,   8'd255, 16'd1,     8'd45, 1'b0, 16};
      vecs[8] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,  1'b1, 0};

      reset_n   = 1'b0;
      on_off    = 1'b1;
      valid_in  = 1'b0;
      ready_out = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #12;
      check("reset_valid_out", valid_out, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_div_by_zero", div_by_zero, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         do_div(vecs[i].dvd, vecs[i].dvs, lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
         check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
         check($sformatf("v%0d_div_by_zero", i), div_by_zero, vecs[i].dbz);
         check($sformatf("v%0d_ready_in_done", i), ready_in, 0);
         handoff();
      end

      // Backpressure: result must hold while ready_out stays low.
      do_div(16'd200, 8'd3, lat);
      check("bp_latency", lat, 16);
      repeat (4) begin
         @(posedge clk);
         #1;
         check("bp_valid_hold", valid_out, 1);
         check("bp_quotient_hold", quotient, 66);
         check("bp_remainder_hold", remainder, 2);
         check("bp_ready_in_low", ready_in, 0);
      end
      handoff();

      // valid_in during the DONE handoff edge is not accepted until IDLE.
      do_div(16'd50, 8'd5, lat);
      check("sim_first_quotient", quotient, 10);
      dividend  = 16'd77;
      divisor   = 8'd7;
      valid_in  = 1'b1;
      ready_out = 1'b1;
      @(posedge clk);
      #1;
      ready_out = 1'b0;
      check("sim_valid_dropped", valid_out, 0);
      check("sim_not_accepted", ready_in, 1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      check("sim_accepted_next", ready_in, 0);
      wait_valid(lat);
      check("sim_latency", lat, 16);
      check("sim_quotient", quotient, 11);
      check("sim_remainder", remainder, 0);
      handoff();

      // on_off dropped mid-CALC aborts and clears the held result.
      dividend = 16'd1000;
      divisor  = 8'd7;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      on_off = 1'b0;
      @(posedge clk);
      #1;
      check("abort_valid_out", valid_out, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      valid_in = 1'b1;
      #1;
      check("off_ready_in", ready_in, 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (valid_out) seen++;
      end
      check("abort_no_valid_out", seen, 0);
      valid_in = 1'b0;
      on_off   = 1'b1;
      #1;
      check("off_no_accept", ready_in, 1);

      // Asynchronous reset between edges mid-CALC clears everything at once.
      do_div(16'd200, 8'd3, lat);
      check("pre_reset_quotient", quotient, 66);
      handoff();
      dividend = 16'd100;
      divisor  = 8'd7;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_valid_out", valid_out, 0);
      check("async_reset_quotient", quotient, 0);
      check("async_reset_remainder", remainder, 0);
      check("async_reset_div_by_zero", div_by_zero, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      do_div(16'd100, 8'd10, lat);
      check("post_reset_latency", lat, 16);
      check("post_reset_quotient", quotient, 10);
      check("post_reset_remainder", remainder, 0);
      handoff();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
